mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port among N cache clients.
// Per-client request FIFOs; posted writes; at most one outstanding read.
module mem_arbiter #(
  parameter int unsigned N_CLIENTS  = 2,
  parameter int unsigned PA_WIDTH   = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_CLIENTS-1:0]                  i_req_enable,
  input  logic [N_CLIENTS-1:0]                  i_req_type,
  input  logic [N_CLIENTS-1:0][PA_WIDTH-1:0]    i_req_addr,
  input  logic [N_CLIENTS-1:0][LINE_WIDTH-1:0]  i_req_data,
  input  logic [N_CLIENTS-1:0]                  i_req_ack,
  output logic [N_CLIENTS-1:0]                  o_rsp_enable,
  output logic [PA_WIDTH-1:0]                   o_rsp_addr,
  output logic [LINE_WIDTH-1:0]                 o_rsp_data,
  output logic [N_CLIENTS-1:0]                  o_full,
  output logic [N_CLIENTS-1:0]                  o_overflow,
  output logic                                  o_mem_valid,
  output logic                                  o_mem_type,
  output logic [PA_WIDTH-1:0]                   o_mem_addr,
  output logic [LINE_WIDTH-1:0]                 o_mem_data,
  input  logic                                  i_mem_ready,
  input  logic                                  i_mem_rsp_valid,
  input  logic [PA_WIDTH-1:0]                   i_mem_rsp_addr,
  input  logic [LINE_WIDTH-1:0]                 i_mem_rsp_data
);

  localparam int unsigned IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DELIVER} state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic [IDX_W-1:0]        r_owner;
  logic [N_CLIENTS-1:0]    r_rsp_enable;
  logic [PA_WIDTH-1:0]     r_rsp_addr;
  logic [LINE_WIDTH-1:0]   r_rsp_data;
  logic                    r_mem_valid;
  logic                    r_mem_type;
  logic [PA_WIDTH-1:0]     r_mem_addr;
  logic [LINE_WIDTH-1:0]   r_mem_data;
  logic [N_CLIENTS-1:0]    r_overflow;

  logic                    r_fifo_type [N_CLIENTS][FIFO_DEPTH];
  logic [PA_WIDTH-1:0]     r_fifo_addr [N_CLIENTS][FIFO_DEPTH];
  logic [LINE_WIDTH-1:0]   r_fifo_data [N_CLIENTS][FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr    [N_CLIENTS];
  logic [PTR_W-1:0]        r_rd_ptr    [N_CLIENTS];
  logic [CNT_W-1:0]        r_count     [N_CLIENTS];

  logic [N_CLIENTS-1:0]    w_nonempty;
  logic [N_CLIENTS-1:0]    w_push;
  logic [N_CLIENTS-1:0]    w_pop;
  logic                    w_grant_valid;
  logic [IDX_W-1:0]        w_grant_idx;
  logic [IDX_W-1:0]        w_next_ptr;
  logic [IDX_W-1:0]        w_cand;

  // Full is judged before any same-cycle pop, so a full FIFO never takes a push.
  always_comb begin
    w_nonempty = '0;
    w_push     = '0;
    o_full     = '0;
    for (int k = 0; k < int'(N_CLIENTS); k++) begin
      w_nonempty[k] = (r_count[k] != '0);
      o_full[k]     = (r_count[k] == CNT_W'(FIFO_DEPTH));
      w_push[k]     = i_req_enable[k] && !o_full[k];
    end
  end

  // First non-empty client at or above the round-robin pointer, with wrap.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    for (int i = int'(N_CLIENTS) - 1; i >= 0; i--) begin
      w_cand = IDX_W'((int'(r_rr_ptr) + i) % int'(N_CLIENTS));
      if (w_nonempty[w_cand]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = w_cand;
      end
    end
    w_next_ptr = (w_grant_idx == IDX_W'(N_CLIENTS - 1)) ? '0 : w_grant_idx + IDX_W'(1);
    w_pop = '0;
    for (int k = 0; k < int'(N_CLIENTS); k++) begin
      w_pop[k] = (r_state == IDLE) && w_grant_valid && (w_grant_idx == IDX_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(N_CLIENTS); k++) begin
      if (w_push[k]) begin
        r_fifo_type[k][r_wr_ptr[k]] <= i_req_type[k];
        r_fifo_addr[k][r_wr_ptr[k]] <= i_req_addr[k];
        r_fifo_data[k][r_wr_ptr[k]] <= i_req_data[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(N_CLIENTS); k++) begin
        r_wr_ptr[k] <= '0;
        r_rd_ptr[k] <= '0;
        r_count[k]  <= '0;
      end
      r_overflow <= '0;
    end else begin
      for (int k = 0; k < int'(N_CLIENTS); k++) begin
        if (w_push[k]) r_wr_ptr[k] <= r_wr_ptr[k] + PTR_W'(1);
        if (w_pop[k])  r_rd_ptr[k] <= r_rd_ptr[k] + PTR_W'(1);
        if (w_push[k] && !w_pop[k])      r_count[k] <= r_count[k] + CNT_W'(1);
        else if (!w_push[k] && w_pop[k]) r_count[k] <= r_count[k] - CNT_W'(1);
        if (i_req_enable[k] && o_full[k]) r_overflow[k] <= 1'b1;
      end
    end
  end

  // Arbitration FSM; the o_mem_* registers double as the issue register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_rsp_enable <= '0;
      r_rsp_addr   <= '0;
      r_rsp_data   <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_type   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_mem_type  <= r_fifo_type[w_grant_idx][r_rd_ptr[w_grant_idx]];
            r_mem_addr  <= r_fifo_addr[w_grant_idx][r_rd_ptr[w_grant_idx]];
            r_mem_data  <= r_fifo_data[w_grant_idx][r_rd_ptr[w_grant_idx]];
            r_mem_valid <= 1'b1;
            r_owner     <= w_grant_idx;
            r_rr_ptr    <= w_next_ptr;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_mem_ready) begin
            r_mem_valid <= 1'b0;
            r_state     <= r_mem_type ? IDLE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (i_mem_rsp_valid) begin
            r_rsp_addr            <= i_mem_rsp_addr;
            r_rsp_data            <= i_mem_rsp_data;
            r_rsp_enable[r_owner] <= 1'b1;
            r_state               <= DELIVER;
          end
        end
        DELIVER: begin
          if (i_req_ack[r_owner]) begin
            r_rsp_enable <= '0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_rsp_enable = r_rsp_enable;
  assign o_rsp_addr   = r_rsp_addr;
  assign o_rsp_data   = r_rsp_data;
  assign o_overflow   = r_overflow;
  assign o_mem_valid  = r_mem_valid;
  assign o_mem_type   = r_mem_type;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_data   = r_mem_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboards for memory requests and fill
// responses, plus cycle-level checks of latency, hold, overflow and reset.
module tb_mem_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;

  typedef struct packed {
    logic          typ;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_t;

  typedef struct packed {
    logic [N-1:0]  en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rsp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N-1:0]          i_req_enable = '0;
  logic [N-1:0]          i_req_type = '0;
  logic [N-1:0][AW-1:0]  i_req_addr = '0;
  logic [N-1:0][DW-1:0]  i_req_data = '0;
  logic [N-1:0]          i_req_ack = '0;
  logic [N-1:0]          o_rsp_enable;
  logic [AW-1:0]         o_rsp_addr;
  logic [DW-1:0]         o_rsp_data;
  logic [N-1:0]          o_full;
  logic [N-1:0]          o_overflow;
  logic                  o_mem_valid;
  logic                  o_mem_type;
  logic [AW-1:0]         o_mem_addr;
  logic [DW-1:0]         o_mem_data;
  logic                  i_mem_ready = 1'b0;
  logic                  i_mem_rsp_valid = 1'b0;
  logic [AW-1:0]         i_mem_rsp_addr = '0;
  logic [DW-1:0]         i_mem_rsp_data = '0;

  int   n_cmp  = 0;
  int   n_fail = 0;
  mem_t exp_mem[$];
  rsp_t exp_rsp[$];

  localparam logic [DW-1:0] D_A5 = {16{8'hA5}};
  localparam logic [DW-1:0] D_12 = {8{16'h1234}};

  mem_arbiter #(.N_CLIENTS(N), .PA_WIDTH(AW), .LINE_WIDTH(DW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .i_req_enable(i_req_enable), .i_req_type(i_req_type),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_ack(i_req_ack),
    .o_rsp_enable(o_rsp_enable), .o_rsp_addr(o_rsp_addr), .o_rsp_data(o_rsp_data),
    .o_full(o_full), .o_overflow(o_overflow),
    .o_mem_valid(o_mem_valid), .o_mem_type(o_mem_type),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .i_mem_ready(i_mem_ready), .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rsp_addr(i_mem_rsp_addr), .i_mem_rsp_data(i_mem_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input logic typ, input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_req_enable[k] = 1'b1;
    i_req_type[k]   = typ;
    i_req_addr[k]   = a;
    i_req_data[k]   = d;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!o_mem_valid && n < 50) begin
      step();
      n++;
    end
    if (!o_mem_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  // Accept a read, answer it after a delay, hold the fill for 3 cycles, then ack.
  task automatic serve_read(input logic [N-1:0] mask, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_valid("rd");
    check("rd_type", o_mem_type, 0);
    check("rd_addr", o_mem_addr, a);
    step();
    repeat (4) begin
      check("wait_no_issue", o_mem_valid, 0);
      check("wait_no_rsp", o_rsp_enable, 0);
      step();
    end
    i_mem_rsp_valid = 1'b1;
    i_mem_rsp_addr  = a;
    i_mem_rsp_data  = d;
    exp_rsp.push_back('{en: mask, addr: a, data: d});
    step();
    i_mem_rsp_valid = 1'b0;
    i_mem_rsp_addr  = '1;
    i_mem_rsp_data  = '1;
    i_req_ack       = ~mask;
    repeat (2) begin
      check("dlv_enable", o_rsp_enable, mask);
      check("dlv_addr", o_rsp_addr, a);
      check("dlv_no_issue", o_mem_valid, 0);
      step();
    end
    i_req_ack = mask;
    check("dlv_enable_ack", o_rsp_enable, mask);
    step();
    i_req_ack = '0;
    check("dlv_released", o_rsp_enable, 0);
  endtask

  // Scoreboard: memory handshakes and acked fills are popped and compared.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_mem_valid && i_mem_ready) begin
        if (exp_mem.size() == 0) check("mem_unexpected", 1, 0);
        else begin
          mem_t m;
          m = exp_mem.pop_front();
          check("sb_mem_type", o_mem_type, m.typ);
          check("sb_mem_addr", o_mem_addr, m.addr);
          if (m.typ) check("sb_mem_data", o_mem_data, m.data);
        end
      end
      if ((o_rsp_enable & i_req_ack) != '0) begin
        if (exp_rsp.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          check("sb_rsp_en", o_rsp_enable, r.en);
          check("sb_rsp_addr", o_rsp_addr, r.addr);
          check("sb_rsp_data", o_rsp_data, r.data);
        end
      end
    end
  end

  initial begin
    step();
    step();
    check("rst_mem_valid", o_mem_valid, 0);
    check("rst_rsp_en", o_rsp_enable, 0);
    check("rst_full", o_full, 0);
    check("rst_ovf", o_overflow, 0);
    rst = 1'b0;
    step();

    // Write latency: pulse in cycle 0, o_mem_valid in cycle 2.
    i_mem_ready = 1'b1;
    req(0, 1'b1, 32'h40, D_A5);
    exp_mem.push_back('{typ: 1'b1, addr: 32'h40, data: D_A5});
    step();
    i_req_enable = '0;
    check("wr_lat_c1", o_mem_valid, 0);
    step();
    check("wr_lat_c2", o_mem_valid, 1);
    check("wr_type", o_mem_type, 1);
    check("wr_addr", o_mem_addr, 32'h40);
    step();
    repeat (3) begin
      check("wr_done_valid", o_mem_valid, 0);
      check("wr_no_rsp", o_rsp_enable, 0);
      step();
    end

    // Single read from client 1.
    req(1, 1'b0, 32'h80, '0);
    exp_mem.push_back('{typ: 1'b0, addr: 32'h80, data: '0});
    step();
    i_req_enable = '0;
    serve_read(2'b10, 32'h80, D_12);

    // Simultaneous reads: client 0 first, client 1 only after client 0's ack.
    req(0, 1'b0, 32'h100, '0);
    req(1, 1'b0, 32'h200, '0);
    exp_mem.push_back('{typ: 1'b0, addr: 32'h100, data: '0});
    exp_mem.push_back('{typ: 1'b0, addr: 32'h200, data: '0});
    step();
    i_req_enable = '0;
    serve_read(2'b01, 32'h100, {4{32'hCAFE0001}});
    serve_read(2'b10, 32'h200, {4{32'hCAFE0002}});

    // Pointer is back at 0: simultaneous writes grant client 0 first.
    req(0, 1'b1, 32'h140, {4{32'h0000_0140}});
    req(1, 1'b1, 32'h240, {4{32'h0000_0240}});
    exp_mem.push_back('{typ: 1'b1, addr: 32'h140, data: {4{32'h0000_0140}}});
    exp_mem.push_back('{typ: 1'b1, addr: 32'h240, data: {4{32'h0000_0240}}});
    step();
    i_req_enable = '0;
    wait_valid("ptr_w0");
    check("ptr_first_addr", o_mem_addr, 32'h140);
    step();
    wait_valid("ptr_w1");
    check("ptr_second_addr", o_mem_addr, 32'h240);
    step();
    step();

    // Overflow: port stalled, client 0 fills its FIFO and loses a third write.
    i_mem_ready = 1'b0;
    req(1, 1'b1, 32'h500, {4{32'h5}});
    exp_mem.push_back('{typ: 1'b1, addr: 32'h500, data: {4{32'h5}}});
    step();
    i_req_enable = '0;
    wait_valid("ovf_stall");
    req(0, 1'b1, 32'h600, {4{32'h6}});
    exp_mem.push_back('{typ: 1'b1, addr: 32'h600, data: {4{32'h6}}});
    step();
    check("ovf_full_1push", o_full[0], 0);
    req(0, 1'b1, 32'h610, {4{32'h61}});
    exp_mem.push_back('{typ: 1'b1, addr: 32'h610, data: {4{32'h61}}});
    step();
    check("ovf_full_2push", o_full[0], 1);
    check("ovf_not_yet", o_overflow, 0);
    req(0, 1'b1, 32'h620, {4{32'h62}});
    step();
    i_req_enable = '0;
    check("ovf_set", o_overflow, 2'b01);
    i_mem_ready = 1'b1;
    repeat (3) begin
      wait_valid("ovf_drain");
      step();
    end
    step();
    check("ovf_drained_full", o_full, 0);
    check("ovf_sticky", o_overflow, 2'b01);

    // Same-client order: write then read to the same line.
    req(0, 1'b1, 32'h40, D_A5);
    exp_mem.push_back('{typ: 1'b1, addr: 32'h40, data: D_A5});
    step();
    req(0, 1'b0, 32'h40, '0);
    exp_mem.push_back('{typ: 1'b0, addr: 32'h40, data: '0});
    step();
    i_req_enable = '0;
    wait_valid("ord_wr");
    check("ord_first_type", o_mem_type, 1);
    step();
    serve_read(2'b01, 32'h40, {4{32'hBEEF0040}});

    // Reset during WAIT_RSP drops the read; a late memory response is ignored.
    req(1, 1'b0, 32'h300, '0);
    exp_mem.push_back('{typ: 1'b0, addr: 32'h300, data: '0});
    step();
    i_req_enable = '0;
    wait_valid("rst_rd");
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_mem_valid", o_mem_valid, 0);
    check("rst2_mem_addr", o_mem_addr, 0);
    check("rst2_rsp_en", o_rsp_enable, 0);
    check("rst2_ovf", o_overflow, 0);
    check("rst2_full", o_full, 0);
    i_mem_rsp_valid = 1'b1;
    i_mem_rsp_addr  = 32'h300;
    i_mem_rsp_data  = D_12;
    step();
    i_mem_rsp_valid = 1'b0;
    repeat (3) begin
      check("late_rsp_en", o_rsp_enable, 0);
      check("late_rsp_addr", o_rsp_addr, 0);
      check("late_mem_valid", o_mem_valid, 0);
      step();
    end
    req(0, 1'b1, 32'h700, {4{32'h7}});
    exp_mem.push_back('{typ: 1'b1, addr: 32'h700, data: {4{32'h7}}});
    step();
    i_req_enable = '0;
    check("post_rst_c1", o_mem_valid, 0);
    step();
    check("post_rst_c2", o_mem_valid, 1);
    check("post_rst_addr", o_mem_addr, 32'h700);
    step();
    step();

    check("mem_queue_drained", exp_mem.size(), 0);
    check("rsp_queue_drained", exp_rsp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
